input_command_gen: RTL and testbench

Turns raw PS/2 set-2 scancode bytes and a gravity timer into one-hot game commands for the gameplay state machine. Handles make/break decoding, held-key tracking, DAS/ARR auto-repeat, and Konami sequence detection. Presents one command at a time on `keyboardinput[8:0]` with a valid/ack handshake. Sits between the PS/2 receiver and the gameplay state machine.

---
 rtl/input_command_gen.sv | 276 +++++++++++++++++++++++++++
 tb/tb_input_command_gen.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/input_command_gen.sv
// PS/2 set-2 scancode front end: make/break decode, held-key tracking, DAS/ARR
// auto-repeat, gravity tick and Konami detection feeding a one-at-a-time valid/ack command port.
module input_command_gen #(
  parameter int GRAVITY_TICKS = 5_000_000,
  parameter int DAS_TICKS     = 8_000_000,
  parameter int ARR_TICKS     = 1_500_000,
  parameter int CW            = 26
) (
  input  logic       Clk,
  input  logic       RESET,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  input  logic       gravity_en,
  input  logic       cmd_ack,
  output logic [8:0] keyboardinput,
  output logic       cmd_valid,
  output logic [6:0] keys_held
);

  localparam int C_LEFT = 0, C_RIGHT = 1, C_SOFTDROP = 2, C_HARDDROP = 3;
  localparam int C_ROTL = 4, C_ROTR = 5, C_HOLD = 6, C_FALL = 7, C_KONAMI = 8;

  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] GRAV_LAST = CW'(GRAVITY_TICKS - 1);
  localparam logic [CW-1:0] DAS_LAST  = CW'(DAS_TICKS - 1);
  localparam logic [CW-1:0] ARR_LAST  = CW'(ARR_TICKS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} dec_state_t;
  typedef enum logic [2:0] {K_UP, K_DOWN, K_LEFT, K_RIGHT, K_B, K_A, K_OTHER} kon_sym_t;

  function automatic logic [6:0] key_map(input logic ext, input logic [7:0] code);
    logic [6:0] oh;
    oh = 7'b0;
    if (ext) begin
      case (code)
        8'h6B:   oh[C_LEFT]     = 1'b1;
        8'h74:   oh[C_RIGHT]    = 1'b1;
        8'h72:   oh[C_SOFTDROP] = 1'b1;
        8'h75:   oh[C_ROTR]     = 1'b1;
        default: oh = 7'b0;
      endcase
    end else begin
      case (code)
        8'h29:   oh[C_HARDDROP] = 1'b1;
        8'h1A:   oh[C_ROTL]     = 1'b1;
        8'h22:   oh[C_ROTR]     = 1'b1;
        8'h21:   oh[C_HOLD]     = 1'b1;
        default: oh = 7'b0;
      endcase
    end
    return oh;
  endfunction

  function automatic kon_sym_t kon_sym(input logic ext, input logic [7:0] code);
    kon_sym_t s;
    s = K_OTHER;
    if (ext) begin
      case (code)
        8'h75:   s = K_UP;
        8'h72:   s = K_DOWN;
        8'h6B:   s = K_LEFT;
        8'h74:   s = K_RIGHT;
        default: s = K_OTHER;
      endcase
    end else begin
      case (code)
        8'h32:   s = K_B;
        8'h1C:   s = K_A;
        default: s = K_OTHER;
      endcase
    end
    return s;
  endfunction

  function automatic kon_sym_t kon_expect(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd1: return K_UP;
      4'd2, 4'd3: return K_DOWN;
      4'd4, 4'd6: return K_LEFT;
      4'd5, 4'd7: return K_RIGHT;
      4'd8:       return K_B;
      4'd9:       return K_A;
      default:    return K_OTHER;
    endcase
  endfunction

  dec_state_t    state_q, state_d;
  logic [6:0]    held_q, held_d;
  logic [8:0]    pend_q, pend_d;
  logic [8:0]    kbd_q, kbd_d;
  logic          valid_q, valid_d;
  logic [CW-1:0] grav_cnt_q, grav_cnt_d;
  logic [CW-1:0] rep_cnt_q, rep_cnt_d;
  logic [2:0]    rep_key_q, rep_key_d;
  logic          rep_arr_q, rep_arr_d;
  logic [3:0]    kon_idx_q, kon_idx_d;

  logic          make_s, brk_s, ext_s, fresh_make_s;
  logic [6:0]    key_oh_s;
  logic [8:0]    set_s, pick_s, clr_s;
  logic [CW-1:0] rep_last_s;
  kon_sym_t      sym_s;

  // Scancode prefix decoder: each accepted byte advances the FSM once
  always_comb begin
    state_d = state_q;
    make_s  = 1'b0;
    brk_s   = 1'b0;
    ext_s   = 1'b0;
    if (scan_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (scan_code == 8'hE0) begin
            state_d = ST_EXT;
          end else if (scan_code == 8'hF0) begin
            state_d = ST_BRK;
          end else if (scan_code == 8'hE1 || scan_code == 8'hAA || scan_code == 8'hFA) begin
            state_d = ST_IDLE;
          end else begin
            make_s = 1'b1;
          end
        end
        ST_EXT: begin
          if (scan_code == 8'hF0) begin
            state_d = ST_EXT_BRK;
          end else begin
            make_s  = 1'b1;
            ext_s   = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_BRK: begin
          brk_s   = 1'b1;
          state_d = ST_IDLE;
        end
        ST_EXT_BRK: begin
          brk_s   = 1'b1;
          ext_s   = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Event sources (keys, repeat, gravity, Konami) and command arbitration
  always_comb begin
    key_oh_s     = key_map(ext_s, scan_code);
    sym_s        = kon_sym(ext_s, scan_code);
    // Typematic repeats of a held key are invisible to everything downstream
    fresh_make_s = make_s && ((key_oh_s & held_q) == 7'b0);
    set_s        = 9'b0;

    if (fresh_make_s) begin
      held_d      = held_q | key_oh_s;
      set_s[6:0]  = key_oh_s;
    end else if (brk_s) begin
      held_d = held_q & ~key_oh_s;
    end else begin
      held_d = held_q;
    end

    if (!gravity_en) begin
      grav_cnt_d = CNT_ZERO;
    end else if (grav_cnt_q == GRAV_LAST) begin
      grav_cnt_d    = CNT_ZERO;
      set_s[C_FALL] = 1'b1;
    end else begin
      grav_cnt_d = grav_cnt_q + CNT_ONE;
    end

    // rep_key is one-hot over LEFT/RIGHT/SOFTDROP; zero means no repeat running
    rep_last_s = rep_arr_q ? ARR_LAST : DAS_LAST;
    rep_key_d  = rep_key_q;
    rep_cnt_d  = rep_cnt_q;
    rep_arr_d  = rep_arr_q;
    if (fresh_make_s && (key_oh_s[2:0] != 3'b0)) begin
      rep_key_d = key_oh_s[2:0];
      rep_cnt_d = CNT_ZERO;
      rep_arr_d = 1'b0;
    end else if (brk_s && ((key_oh_s[2:0] & rep_key_q) != 3'b0)) begin
      rep_key_d = 3'b0;
    end else if (rep_key_q != 3'b0) begin
      if (rep_cnt_q == rep_last_s) begin
        rep_cnt_d  = CNT_ZERO;
        rep_arr_d  = 1'b1;
        set_s[2:0] = set_s[2:0] | rep_key_q;
      end else begin
        rep_cnt_d = rep_cnt_q + CNT_ONE;
      end
    end else begin
      rep_cnt_d = rep_cnt_q;
    end

    if (fresh_make_s) begin
      if (sym_s == kon_expect(kon_idx_q)) begin
        if (kon_idx_q == 4'd9) begin
          kon_idx_d       = 4'd0;
          set_s[C_KONAMI] = 1'b1;
        end else begin
          kon_idx_d = kon_idx_q + 4'd1;
        end
      end else if (sym_s == K_UP && kon_idx_q == 4'd2) begin
        kon_idx_d = 4'd2;
      end else if (sym_s == K_UP) begin
        kon_idx_d = 4'd1;
      end else begin
        kon_idx_d = 4'd0;
      end
    end else begin
      kon_idx_d = kon_idx_q;
    end

    pick_s = 9'b0;
    if (pend_q[C_KONAMI])        pick_s[C_KONAMI]   = 1'b1;
    else if (pend_q[C_HARDDROP]) pick_s[C_HARDDROP] = 1'b1;
    else if (pend_q[C_HOLD])     pick_s[C_HOLD]     = 1'b1;
    else if (pend_q[C_ROTR])     pick_s[C_ROTR]     = 1'b1;
    else if (pend_q[C_ROTL])     pick_s[C_ROTL]     = 1'b1;
    else if (pend_q[C_LEFT])     pick_s[C_LEFT]     = 1'b1;
    else if (pend_q[C_RIGHT])    pick_s[C_RIGHT]    = 1'b1;
    else if (pend_q[C_SOFTDROP]) pick_s[C_SOFTDROP] = 1'b1;
    else if (pend_q[C_FALL])     pick_s[C_FALL]     = 1'b1;
    else                         pick_s             = 9'b0;

    if (valid_q && cmd_ack) begin
      valid_d = 1'b0;
      kbd_d   = 9'b0;
    end else if (!valid_q && (pend_q != 9'b0)) begin
      valid_d = 1'b1;
      kbd_d   = pick_s;
    end else begin
      valid_d = valid_q;
      kbd_d   = kbd_q;
    end

    // A new event on the bit being loaded wins over the clear
    clr_s  = valid_q ? 9'b0 : pick_s;
    pend_d = (pend_q & ~clr_s) | set_s;
  end

  // State registers
  always_ff @(posedge Clk) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      held_q     <= 7'b0;
      pend_q     <= 9'b0;
      kbd_q      <= 9'b0;
      valid_q    <= 1'b0;
      grav_cnt_q <= CNT_ZERO;
      rep_cnt_q  <= CNT_ZERO;
      rep_key_q  <= 3'b0;
      rep_arr_q  <= 1'b0;
      kon_idx_q  <= 4'd0;
    end else begin
      state_q    <= state_d;
      held_q     <= held_d;
      pend_q     <= pend_d;
      kbd_q      <= kbd_d;
      valid_q    <= valid_d;
      grav_cnt_q <= grav_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      rep_key_q  <= rep_key_d;
      rep_arr_q  <= rep_arr_d;
      kon_idx_q  <= kon_idx_d;
    end
  end

  assign keyboardinput = kbd_q;
  assign cmd_valid     = valid_q;
  assign keys_held     = held_q;

endmodule

// File: tb/tb_input_command_gen.sv
// Scoreboard bench for input_command_gen: directed scancode streams push expected
// commands; a negedge monitor pops one per accepted (valid && ack) command.
module tb_input_command_gen;

  logic       Clk = 1'b0;
  logic       RESET;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       gravity_en;
  logic       cmd_ack;
  logic [8:0] keyboardinput;
  logic       cmd_valid;
  logic [6:0] keys_held;

  input_command_gen #(
    .GRAVITY_TICKS(8),
    .DAS_TICKS(10),
    .ARR_TICKS(4),
    .CW(8)
  ) dut (
    .Clk(Clk),
    .RESET(RESET),
    .scan_code(scan_code),
    .scan_valid(scan_valid),
    .gravity_en(gravity_en),
    .cmd_ack(cmd_ack),
    .keyboardinput(keyboardinput),
    .cmd_valid(cmd_valid),
    .keys_held(keys_held)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [8:0] cmd;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc    = 0;
  int   passed = 0;
  int   total  = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  always @(negedge Clk) begin
    if (!RESET && cmd_valid && cmd_ack) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_cmd: got 0x%0h, required none (cycle %0d)", keyboardinput, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("cmd", {23'b0, keyboardinput}, {23'b0, mon_e.cmd});
        if (mon_e.cyc >= 0) check("cmd_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic push(input logic [8:0] c, input int at);
    exp_t e;
    e.cmd = c;
    e.cyc = at;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    scan_code  = b;
    scan_valid = 1'b1;
    tick(1);
    scan_valid = 1'b0;
  endtask

  task automatic key_tap(input logic ext, input logic [7:0] code);
    if (ext) send_byte(8'hE0);
    send_byte(code);
    if (ext) send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(code);
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    tick(12);
    check(name, exp_q.size(), 0);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    while (!cmd_valid && n < budget) begin
      tick(1);
      n++;
    end
    check(name, {31'b0, cmd_valid}, 32'd1);
  endtask

  logic       kon_ext  [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [7:0] kon_code [11] = '{8'h75, 8'h75, 8'h75, 8'h72, 8'h72, 8'h6B, 8'h74, 8'h6B, 8'h74, 8'h32, 8'h1C};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

  initial begin
    int t;
    RESET      = 1'b1;
    scan_code  = 8'h00;
    scan_valid = 1'b0;
    gravity_en = 1'b0;
    cmd_ack    = 1'b0;
    tick(3);
    check("reset_kbd", {23'b0, keyboardinput}, 32'h0);
    check("reset_valid", {31'b0, cmd_valid}, 32'h0);
    check("reset_held", {25'b0, keys_held}, 32'h0);
    RESET = 1'b0;
    tick(1);

    // Reset between E0 and 6B: 6B must decode as an unmapped non-extended make
    cmd_ack = 1'b1;
    send_byte(8'hE0);
    RESET = 1'b1;
    tick(1);
    RESET = 1'b0;
    send_byte(8'h6B);
    tick(5);
    check("midreset_held", {25'b0, keys_held}, 32'h0);
    check("midreset_valid", {31'b0, cmd_valid}, 32'h0);
    drain("midreset_drain", 5);

    // HARDDROP make/break with ack tied high: exactly one pulse
    t = cyc + 1;
    push(9'h008, t + 1);
    send_byte(8'h29);
    check("hd_held_make", {25'b0, keys_held}, 32'h08);
    send_byte(8'hF0);
    send_byte(8'h29);
    check("hd_held_break", {25'b0, keys_held}, 32'h00);
    drain("hd_drain", 20);

    // LEFT with DAS=10, ARR=4, held then released
    send_byte(8'hE0);
    t = cyc + 1;
    push(9'h001, t + 1);
    push(9'h001, t + 11);
    push(9'h001, t + 15);
    push(9'h001, t + 19);
    send_byte(8'h6B);
    check("left_held", {25'b0, keys_held}, 32'h01);
    tick(18);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h6B);
    check("left_released", {25'b0, keys_held}, 32'h00);
    drain("das_drain", 20);

    // Priority/merge: FALL occupies the output while ROTL, HARDDROP, HOLD and a second FALL queue up
    cmd_ack    = 1'b0;
    gravity_en = 1'b1;
    wait_valid("prio_fall_wait", 20);
    check("prio_occupant", {23'b0, keyboardinput}, 32'h080);
    push(9'h080, -1);
    push(9'h008, -1);
    push(9'h040, -1);
    push(9'h010, -1);
    push(9'h080, -1);
    send_byte(8'h1A);
    send_byte(8'h29);
    send_byte(8'h21);
    tick(6);
    gravity_en = 1'b0;
    tick(2);
    check("prio_held", {25'b0, keys_held}, 32'h58);
    check("prio_still_occupant", {23'b0, keyboardinput}, 32'h080);
    cmd_ack = 1'b1;
    send_byte(8'hF0);
    send_byte(8'h1A);
    send_byte(8'hF0);
    send_byte(8'h29);
    send_byte(8'hF0);
    send_byte(8'h21);
    drain("prio_drain", 30);
    check("prio_held_clear", {25'b0, keys_held}, 32'h00);

    // Konami with an extra leading Up; ack held low so KONAMI must jump the queue
    cmd_ack = 1'b0;
    push(9'h020, -1);
    push(9'h100, -1);
    push(9'h020, -1);
    push(9'h001, -1);
    push(9'h002, -1);
    push(9'h004, -1);
    for (int i = 0; i < 11; i++) key_tap(kon_ext[i], kon_code[i]);
    tick(3);
    check("kon_held", {25'b0, keys_held}, 32'h00);
    check("kon_occupant", {23'b0, keyboardinput}, 32'h020);
    cmd_ack = 1'b1;
    drain("kon_drain", 30);

    // Stall: ack low for 100 cycles under gravity; FALL stays put, one more stays pending
    cmd_ack    = 1'b0;
    gravity_en = 1'b1;
    wait_valid("stall_wait", 20);
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      check("stall_kbd", {22'b0, cmd_valid, keyboardinput}, 32'h280);
    end
    tick(1);
    gravity_en = 1'b0;
    tick(1);
    push(9'h080, -1);
    push(9'h080, -1);
    cmd_ack = 1'b1;
    drain("stall_drain", 20);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
